// File: rtl/oled_pkg.sv
// Shared definitions for the OLED serial sink: opcode set, argument counts,
// command FSM encoding and default panel geometry.
package oled_pkg;

    localparam int COLS_DEF  = 128;
    localparam int PAGES_DEF = 4;

    localparam logic [7:0] OP_MEM_MODE     = 8'h20;
    localparam logic [7:0] OP_COL_ADDR     = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;
    localparam logic [7:0] OP_CONTRAST     = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
    localparam logic [7:0] OP_SEG_REMAP0   = 8'hA0;
    localparam logic [7:0] OP_SEG_REMAP1   = 8'hA1;
    localparam logic [7:0] OP_ENTIRE_OFF   = 8'hA4;
    localparam logic [7:0] OP_ENTIRE_ON    = 8'hA5;
    localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
    localparam logic [7:0] OP_DISP_OFF     = 8'hAE;
    localparam logic [7:0] OP_DISP_ON      = 8'hAF;
    localparam logic [7:0] OP_COM_SCAN_INC = 8'hC0;
    localparam logic [7:0] OP_COM_SCAN_DEC = 8'hC8;
    localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
    localparam logic [7:0] OP_COM_PINS     = 8'hDA;
    localparam logic [7:0] OP_VCOMH        = 8'hDB;
    localparam logic [7:0] OP_NOP          = 8'hE3;

    localparam logic [7:0] ADDR_MODE_RST   = 8'h02;

    typedef enum logic [1:0] {
        ST_OP   = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } cmd_state_e;

    // 0x40-0x7F is the display start line range, accepted without arguments.
    function automatic logic op_known(input logic [7:0] op);
        logic known;
        case (op)
            OP_MEM_MODE, OP_COL_ADDR, OP_PAGE_ADDR, OP_CONTRAST, OP_CHARGE_PUMP,
            OP_SEG_REMAP0, OP_SEG_REMAP1, OP_ENTIRE_OFF, OP_ENTIRE_ON,
            OP_MUX_RATIO, OP_DISP_OFF, OP_DISP_ON, OP_COM_SCAN_INC,
            OP_COM_SCAN_DEC, OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE,
            OP_COM_PINS, OP_VCOMH, OP_NOP: known = 1'b1;
            default:                       known = (op[7:6] == 2'b01);
        endcase
        return known;
    endfunction

    function automatic logic [1:0] arg_count(input logic [7:0] op);
        logic [1:0] n;
        case (op)
            OP_COL_ADDR, OP_PAGE_ADDR: n = 2'd2;
            OP_MEM_MODE, OP_CONTRAST, OP_CHARGE_PUMP, OP_MUX_RATIO,
            OP_DISP_OFFSET, OP_CLK_DIV, OP_PRECHARGE, OP_COM_PINS,
            OP_VCOMH:                  n = 2'd1;
            default:                   n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Serial deframer: synchronizes the 3-wire stream, detects SCLK rising edges,
// assembles MSB-first bytes and drops partial bytes after an idle timeout.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYC    = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_i,
    input  logic       sdin_i,
    input  logic       dc_i,
    input  logic       res_i,
    output logic       res_sync_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_is_data_o
);

    localparam int            IW       = $clog2(IDLE_CYC + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYC);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);

    logic [3:0]    sync_q [SYNC_STAGES];
    logic [3:0]    sync_out_s;
    logic          panel_rst_s;
    logic          sclk_prev_q;
    logic          rise_q, bit_q, dcb_q;
    logic [2:0]    cnt_q, cnt_d, cnt_eff_s;
    logic [6:0]    shift_q, shift_d, shift_eff_s;
    logic [IW-1:0] idle_q, idle_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          is_data_q, is_data_d;

    // Synchronizer chain carrying {sclk, sdin, dc, res}; res idles released.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= 4'b0001;
        end else begin
            sync_q[0] <= {sclk_i, sdin_i, dc_i, res_i};
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign sync_out_s  = sync_q[SYNC_STAGES-1];
    assign panel_rst_s = rst | ~sync_out_s[0];
    assign res_sync_o  = sync_out_s[0];

    // Previous SCLK level keeps tracking through panel reset so release
    // never fabricates an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= sync_out_s[3];
        end
    end

    // Registered edge strobe with the data/dc bits captured alongside it.
    always_ff @(posedge clk) begin
        if (panel_rst_s) begin
            rise_q <= 1'b0;
            bit_q  <= 1'b0;
            dcb_q  <= 1'b0;
        end else begin
            rise_q <= sync_out_s[3] & ~sclk_prev_q;
            bit_q  <= sync_out_s[2];
            dcb_q  <= sync_out_s[1];
        end
    end

    // Byte assembly, idle timeout and output strobe next-state.
    always_comb begin
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        idle_d    = idle_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        is_data_d = is_data_q;
        // A saturated idle counter means any partial byte is stale.
        if (idle_q == IDLE_MAX) begin
            cnt_eff_s   = 3'd0;
            shift_eff_s = 7'd0;
        end else begin
            cnt_eff_s   = cnt_q;
            shift_eff_s = shift_q;
        end
        if (rise_q) begin
            idle_d  = {IW{1'b0}};
            shift_d = {shift_eff_s[5:0], bit_q};
            if (cnt_eff_s == 3'd7) begin
                cnt_d     = 3'd0;
                valid_d   = 1'b1;
                data_d    = {shift_eff_s, bit_q};
                is_data_d = dcb_q;
            end else begin
                cnt_d = cnt_eff_s + 3'd1;
            end
        end else begin
            cnt_d   = cnt_eff_s;
            shift_d = shift_eff_s;
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + IDLE_ONE;
            end else begin
                idle_d = idle_q;
            end
        end
    end

    // Byte assembly state registers.
    always_ff @(posedge clk) begin
        if (panel_rst_s) begin
            cnt_q     <= 3'd0;
            shift_q   <= 7'd0;
            idle_q    <= {IW{1'b0}};
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            is_data_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            idle_q    <= idle_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            is_data_q <= is_data_d;
        end
    end

    assign byte_valid_o   = valid_q;
    assign byte_data_o    = data_q;
    assign byte_is_data_o = is_data_q;

endmodule

// File: rtl/oled_spi_sink.sv
// Receive-side OLED panel model: command decode, windowed address counters
// and a page-organised frame buffer with a registered read port.
module oled_spi_sink
    import oled_pkg::*;
#(
    parameter int COLS        = COLS_DEF,
    parameter int PAGES       = PAGES_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYC    = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sclk,
    input  logic                                   sdin,
    input  logic                                   dc,
    input  logic                                   res,
    input  logic                                   vdd,
    input  logic                                   vbat,
    output logic                                   byte_valid,
    output logic [7:0]                             byte_data,
    output logic                                   byte_is_data,
    output logic                                   disp_on,
    output logic                                   entire_on,
    output logic                                   pwr_ok,
    output logic                                   unknown_cmd,
    input  logic [$clog2(COLS)+$clog2(PAGES)-1:0]  fb_rd_addr,
    output logic [7:0]                             fb_rd_data
);

    localparam int            CW        = $clog2(COLS);
    localparam int            PW        = $clog2(PAGES);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);
    localparam logic [CW-1:0] COL_ONE   = CW'(1);
    localparam logic [PW-1:0] PAGE_ONE  = PW'(1);

    logic          rx_valid_s, rx_is_data_s, res_sync_s, panel_rst_s;
    logic [7:0]    rx_byte_s;

    cmd_state_e    state_q, state_d;
    logic [7:0]    op_q, op_d, arg1_q, arg1_d, addr_mode_q, addr_mode_d;
    logic [CW-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
    logic [PW-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
    logic          disp_on_q, disp_on_d, entire_on_q, entire_on_d;
    logic          unknown_q, unknown_d, pwr_ok_q, fb_we_s;
    logic [7:0]    fb_rd_q;
    logic [7:0]    fb_mem [COLS*PAGES];
    logic          unused_addr_mode_s;

    spi_byte_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_CYC    (IDLE_CYC)
    ) u_rx (
        .clk            (clk),
        .rst            (rst),
        .sclk_i         (sclk),
        .sdin_i         (sdin),
        .dc_i           (dc),
        .res_i          (res),
        .res_sync_o     (res_sync_s),
        .byte_valid_o   (rx_valid_s),
        .byte_data_o    (rx_byte_s),
        .byte_is_data_o (rx_is_data_s)
    );

    assign panel_rst_s = rst | ~res_sync_s;

    // Command FSM, window registers and write-pointer advance.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg1_d       = arg1_q;
        addr_mode_d  = addr_mode_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        col_d        = col_q;
        page_d       = page_q;
        disp_on_d    = disp_on_q;
        entire_on_d  = entire_on_q;
        unknown_d    = unknown_q;
        fb_we_s      = 1'b0;
        if (rx_valid_s) begin
            if (rx_is_data_s) begin
                // Data always lands in the buffer and cancels any pending arguments.
                state_d = ST_OP;
                fb_we_s = 1'b1;
                if (col_q == col_end_q) begin
                    col_d = col_start_q;
                    if (page_q == page_end_q) begin
                        page_d = page_start_q;
                    end else begin
                        page_d = page_q + PAGE_ONE;
                    end
                end else begin
                    col_d = col_q + COL_ONE;
                end
            end else begin
                case (state_q)
                    ST_OP: begin
                        op_d = rx_byte_s;
                        case (rx_byte_s)
                            OP_DISP_OFF:   disp_on_d   = 1'b0;
                            OP_DISP_ON:    disp_on_d   = 1'b1;
                            OP_ENTIRE_OFF: entire_on_d = 1'b0;
                            OP_ENTIRE_ON:  entire_on_d = 1'b1;
                            default:       disp_on_d   = disp_on_q;
                        endcase
                        if (!op_known(rx_byte_s)) begin
                            unknown_d = 1'b1;
                        end else if (arg_count(rx_byte_s) != 2'd0) begin
                            state_d = ST_ARG1;
                        end else begin
                            state_d = ST_OP;
                        end
                    end
                    ST_ARG1: begin
                        arg1_d = rx_byte_s;
                        if (op_q == OP_MEM_MODE) begin
                            addr_mode_d = rx_byte_s;
                        end else begin
                            addr_mode_d = addr_mode_q;
                        end
                        if (arg_count(op_q) == 2'd2) begin
                            state_d = ST_ARG2;
                        end else begin
                            state_d = ST_OP;
                        end
                    end
                    ST_ARG2: begin
                        // Both window bounds commit together and re-home the pointer.
                        state_d = ST_OP;
                        if (op_q == OP_COL_ADDR) begin
                            col_start_d = arg1_q[CW-1:0];
                            col_end_d   = rx_byte_s[CW-1:0];
                            col_d       = arg1_q[CW-1:0];
                        end else if (op_q == OP_PAGE_ADDR) begin
                            page_start_d = arg1_q[PW-1:0];
                            page_end_d   = rx_byte_s[PW-1:0];
                            page_d       = arg1_q[PW-1:0];
                        end else begin
                            state_d = ST_OP;
                        end
                    end
                    default: state_d = ST_OP;
                endcase
            end
        end else begin
            fb_we_s = 1'b0;
        end
    end

    // Control state registers; panel reset behaves like rst here.
    always_ff @(posedge clk) begin
        if (panel_rst_s) begin
            state_q      <= ST_OP;
            op_q         <= 8'h00;
            arg1_q       <= 8'h00;
            addr_mode_q  <= ADDR_MODE_RST;
            col_start_q  <= {CW{1'b0}};
            col_end_q    <= COL_LAST;
            page_start_q <= {PW{1'b0}};
            page_end_q   <= PAGE_LAST;
            col_q        <= {CW{1'b0}};
            page_q       <= {PW{1'b0}};
            disp_on_q    <= 1'b0;
            entire_on_q  <= 1'b0;
            unknown_q    <= 1'b0;
            pwr_ok_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg1_q       <= arg1_d;
            addr_mode_q  <= addr_mode_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            col_q        <= col_d;
            page_q       <= page_d;
            disp_on_q    <= disp_on_d;
            entire_on_q  <= entire_on_d;
            unknown_q    <= unknown_d;
            pwr_ok_q     <= ~vdd & ~vbat;
        end
    end

    // Frame buffer write port; contents survive every kind of reset.
    always_ff @(posedge clk) begin
        if (fb_we_s) begin
            fb_mem[{page_q, col_q}] <= rx_byte_s;
        end
    end

    // Registered read port, read-before-write on a colliding address.
    always_ff @(posedge clk) begin
        if (panel_rst_s) begin
            fb_rd_q <= 8'h00;
        end else begin
            fb_rd_q <= fb_mem[fb_rd_addr];
        end
    end

    // addr_mode is retained for observability; nothing consumes it yet.
    assign unused_addr_mode_s = ^addr_mode_q;

    assign byte_valid   = rx_valid_s;
    assign byte_data    = rx_byte_s;
    assign byte_is_data = rx_is_data_s;
    assign disp_on      = disp_on_q;
    assign entire_on    = entire_on_q;
    assign pwr_ok       = pwr_ok_q;
    assign unknown_cmd  = unknown_q;
    assign fb_rd_data   = fb_rd_q;

endmodule
